// File: rtl/ac_select_matcher_pkg.sv
// Shared types and helpers for the ANTICOLLISION/SELECT matcher.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ac_select_matcher_pkg;

  typedef enum logic [1:0] {
    UIDSize_SINGLE,
    UIDSize_DOUBLE,
    UIDSize_TRIPLE
  } UIDSize;

  // NVB byte: upper nibble counts whole bytes, lower nibble counts extra bits
  typedef struct packed {
    logic       rsvd_hi;
    logic [2:0] bytes;
    logic       rsvd_lo;
    logic [2:0] bits;
  } nvb_t;

  localparam logic [7:0] CASCADE_TAG = 8'h88;
  localparam logic [7:0] SEL1        = 8'h93;
  localparam logic [7:0] SEL2        = 8'h95;
  localparam logic [7:0] SEL3        = 8'h97;
  localparam logic [7:0] NVB_SELECT  = 8'h70;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_NVB,
    ST_UID,
    ST_CRC,
    ST_WAIT_EOC,
    ST_IGNORE
  } AcSelState;

  function automatic int get_uid_bits(UIDSize s);
    case (s)
      UIDSize_SINGLE: return 32;
      UIDSize_DOUBLE: return 56;
      default:        return 80;
    endcase
  endfunction

  function automatic logic [1:0] get_num_levels(UIDSize s);
    case (s)
      UIDSize_SINGLE: return 2'd1;
      UIDSize_DOUBLE: return 2'd2;
      default:        return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] sel_for_level(logic [1:0] level);
    case (level)
      2'd0:    return SEL1;
      2'd1:    return SEL2;
      default: return SEL3;
    endcase
  endfunction

endpackage

// File: rtl/ac_select_matcher_uid_level_select.sv
// Maps the tag UID and cascade level to the 4 UID bytes + BCC expected on air.
// Latency: combinational.
// Backpressure: none.
module uid_level_select
  import ac_select_matcher_pkg::*;
#(
  parameter UIDSize UID_SIZE = UIDSize_DOUBLE,
  parameter int     UID_BITS = get_uid_bits(UID_SIZE)
) (
  input  logic [UID_BITS-1:0] uid,
  input  logic [1:0]          cascade_level,
  output logic [39:0]         expected,
  output logic                level_valid
);

  localparam logic [1:0] NUM_LEVELS = get_num_levels(UID_SIZE);

  logic [79:0] uid_ext;
  logic [31:0] level_bytes;
  logic [7:0]  bcc;

  // Non-final levels carry the cascade tag in byte 0 followed by 3 UID bytes
  always_comb begin
    uid_ext                 = '0;
    uid_ext[UID_BITS-1:0]   = uid;
    level_valid             = (cascade_level < NUM_LEVELS);
    level_bytes             = '0;
    if (cascade_level == NUM_LEVELS - 2'd1) begin
      case (cascade_level)
        2'd0:    level_bytes = uid_ext[31:0];
        2'd1:    level_bytes = uid_ext[55:24];
        default: level_bytes = uid_ext[79:48];
      endcase
    end else begin
      case (cascade_level)
        2'd0:    level_bytes = {uid_ext[23:0], CASCADE_TAG};
        2'd1:    level_bytes = {uid_ext[47:24], CASCADE_TAG};
        default: level_bytes = '0;
      endcase
    end
    bcc      = level_bytes[7:0] ^ level_bytes[15:8] ^ level_bytes[23:16] ^ level_bytes[31:24];
    expected = {bcc, level_bytes};
  end

endmodule

// File: rtl/ac_select_matcher.sv
// Parses ANTICOLLISION/SELECT frames bit by bit and matches UID data against this tag.
// Latency: match pulses one cycle after rx_eoc.
// Backpressure: none; the decoded stream is consumed at line rate.
module ac_select_matcher
  import ac_select_matcher_pkg::*;
#(
  parameter UIDSize UID_SIZE = UIDSize_DOUBLE,
  parameter int     UID_BITS = get_uid_bits(UID_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [UID_BITS-1:0] uid,
  input  logic [1:0]          cascade_level,
  input  logic                rx_soc,
  input  logic                rx_valid,
  input  logic                rx_bit,
  input  logic                rx_eoc,
  input  logic                rx_error,
  input  logic                rx_crc_ok,
  output logic                ac_match,
  output logic                sel_match,
  output logic                sel_uid_complete,
  output logic [39:0]         reply_data,
  output logic [5:0]          reply_first_bit,
  output logic [5:0]          reply_num_bits,
  output logic                busy
);

  localparam logic [1:0] NUM_LEVELS = get_num_levels(UID_SIZE);

  AcSelState  state_q, state_b;
  logic [5:0] cnt_q, cnt_b;
  logic [6:0] shreg_q, shreg_b;
  logic       mismatch_q, mismatch_b;
  logic       is_sel_q, is_sel_b;
  logic [5:0] n_q, n_b;
  logic [1:0] level_q;
  logic [7:0] byte_now;
  nvb_t       nvb;
  logic [39:0] level_expected;
  logic        level_valid;

  uid_level_select #(
    .UID_SIZE (UID_SIZE),
    .UID_BITS (UID_BITS)
  ) u_uid_level_select (
    .uid           (uid),
    .cascade_level (cascade_level),
    .expected      (level_expected),
    .level_valid   (level_valid)
  );

  // State after consuming this cycle's bit; eoc is then judged against it
  always_comb begin
    state_b    = state_q;
    cnt_b      = cnt_q;
    shreg_b    = shreg_q;
    mismatch_b = mismatch_q;
    is_sel_b   = is_sel_q;
    n_b        = n_q;
    byte_now   = {rx_bit, shreg_q};
    nvb        = nvb_t'(byte_now);
    if (rx_valid) begin
      shreg_b = byte_now[7:1];
      case (state_q)
        ST_CMD: begin
          if (cnt_q == 6'd7) begin
            cnt_b   = '0;
            state_b = (byte_now == sel_for_level(level_q)) ? ST_NVB : ST_IGNORE;
          end else begin
            cnt_b = cnt_q + 6'd1;
          end
        end
        ST_NVB: begin
          if (cnt_q == 6'd7) begin
            cnt_b = '0;
            if (nvb.rsvd_hi || nvb.rsvd_lo) begin
              state_b = ST_IGNORE;
            end else if (byte_now == NVB_SELECT) begin
              is_sel_b = 1'b1;
              n_b      = 6'd40;
              state_b  = ST_UID;
            end else if (nvb.bytes >= 3'd2 && nvb.bytes <= 3'd6) begin
              is_sel_b = 1'b0;
              n_b      = {nvb.bytes - 3'd2, nvb.bits};
              state_b  = ({nvb.bytes - 3'd2, nvb.bits} == 6'd0) ? ST_WAIT_EOC : ST_UID;
            end else begin
              state_b = ST_IGNORE;
            end
          end else begin
            cnt_b = cnt_q + 6'd1;
          end
        end
        ST_UID: begin
          if (rx_bit != reply_data[cnt_q]) mismatch_b = 1'b1;
          if (cnt_q == n_q - 6'd1) begin
            cnt_b   = '0;
            state_b = is_sel_q ? ST_CRC : ST_WAIT_EOC;
          end else begin
            cnt_b = cnt_q + 6'd1;
          end
        end
        ST_CRC: begin
          if (cnt_q == 6'd15) begin
            cnt_b   = '0;
            state_b = ST_WAIT_EOC;
          end else begin
            cnt_b = cnt_q + 6'd1;
          end
        end
        ST_WAIT_EOC: state_b = ST_IGNORE;
        default: ;
      endcase
    end
  end

  // Frame FSM with registered result pulses; soc beats error beats bit/eoc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      shreg_q          <= '0;
      mismatch_q       <= 1'b0;
      is_sel_q         <= 1'b0;
      n_q              <= '0;
      level_q          <= '0;
      ac_match         <= 1'b0;
      sel_match        <= 1'b0;
      sel_uid_complete <= 1'b0;
      reply_data       <= '0;
      reply_first_bit  <= '0;
      reply_num_bits   <= '0;
      busy             <= 1'b0;
    end else begin
      ac_match  <= 1'b0;
      sel_match <= 1'b0;
      if (rx_soc) begin
        state_q          <= level_valid ? ST_CMD : ST_IGNORE;
        cnt_q            <= '0;
        shreg_q          <= '0;
        mismatch_q       <= 1'b0;
        is_sel_q         <= 1'b0;
        n_q              <= '0;
        level_q          <= cascade_level;
        busy             <= 1'b1;
        reply_data       <= level_expected;
        reply_first_bit  <= '0;
        reply_num_bits   <= '0;
        sel_uid_complete <= (cascade_level == NUM_LEVELS - 2'd1);
      end else if (rx_error) begin
        state_q <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        state_q    <= state_b;
        cnt_q      <= cnt_b;
        shreg_q    <= shreg_b;
        mismatch_q <= mismatch_b;
        is_sel_q   <= is_sel_b;
        n_q        <= n_b;
        if (rx_eoc) begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          if (state_b == ST_WAIT_EOC && !mismatch_b) begin
            if (is_sel_b) begin
              sel_match <= rx_crc_ok;
            end else begin
              ac_match        <= 1'b1;
              reply_first_bit <= n_b;
              reply_num_bits  <= 6'd40 - n_b;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ac_select_matcher.sv
// Directed bench for ac_select_matcher: single- and double-UID instances share stimulus.
// Latency: checks pulses one cycle after rx_eoc.
// Backpressure: n/a.
module tb_ac_select_matcher;
  import ac_select_matcher_pkg::*;

  localparam logic [31:0] UID_S = 32'h12345678;
  localparam logic [55:0] UID_D = 56'h11223344556677;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] cascade_level;
  logic rx_soc, rx_valid, rx_bit, rx_eoc, rx_error, rx_crc_ok;

  logic        s_ac, s_sel, s_cmp, s_busy, d_ac, d_sel, d_cmp, d_busy;
  logic [39:0] s_data, d_data;
  logic [5:0]  s_first, s_num, d_first, d_num;

  logic        dsel;
  logic        o_ac, o_sel, o_cmp, o_busy;
  logic [39:0] o_data;
  logic [5:0]  o_first, o_num;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ac_select_matcher #(.UID_SIZE(UIDSize_SINGLE)) u_single (
    .clk(clk), .rst_n(rst_n), .uid(UID_S), .cascade_level(cascade_level),
    .rx_soc(rx_soc), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_eoc(rx_eoc),
    .rx_error(rx_error), .rx_crc_ok(rx_crc_ok),
    .ac_match(s_ac), .sel_match(s_sel), .sel_uid_complete(s_cmp),
    .reply_data(s_data), .reply_first_bit(s_first), .reply_num_bits(s_num), .busy(s_busy)
  );

  ac_select_matcher #(.UID_SIZE(UIDSize_DOUBLE)) u_double (
    .clk(clk), .rst_n(rst_n), .uid(UID_D), .cascade_level(cascade_level),
    .rx_soc(rx_soc), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_eoc(rx_eoc),
    .rx_error(rx_error), .rx_crc_ok(rx_crc_ok),
    .ac_match(d_ac), .sel_match(d_sel), .sel_uid_complete(d_cmp),
    .reply_data(d_data), .reply_first_bit(d_first), .reply_num_bits(d_num), .busy(d_busy)
  );

  assign o_ac    = dsel ? d_ac    : s_ac;
  assign o_sel   = dsel ? d_sel   : s_sel;
  assign o_cmp   = dsel ? d_cmp   : s_cmp;
  assign o_busy  = dsel ? d_busy  : s_busy;
  assign o_data  = dsel ? d_data  : s_data;
  assign o_first = dsel ? d_first : s_first;
  assign o_num   = dsel ? d_num   : s_num;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rx_soc = 0; rx_valid = 0; rx_bit = 0; rx_eoc = 0; rx_error = 0; rx_crc_ok = 0;
  endtask

  task automatic soc(input logic [1:0] lvl);
    @(negedge clk); clr(); cascade_level = lvl; rx_soc = 1;
  endtask

  task automatic bits(input logic [39:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clr(); rx_valid = 1; rx_bit = v[i];
    end
  endtask

  task automatic byte8(input logic [7:0] b);
    bits({32'h0, b}, 8);
  endtask

  // Drive eoc, then sample the registered pulses one cycle later
  task automatic eoc_check(input string tag, input logic crc, input logic exp_ac, input logic exp_sel);
    @(negedge clk); clr(); rx_eoc = 1; rx_crc_ok = crc;
    @(negedge clk); clr();
    check({tag, "_ac"}, o_ac, exp_ac);
    check({tag, "_sel"}, o_sel, exp_sel);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr(); cascade_level = 0; dsel = 0;
    repeat (3) @(negedge clk);
    check("rst_ac", o_ac, 0);
    check("rst_sel", o_sel, 0);
    check("rst_cmp", o_cmp, 0);
    check("rst_data", o_data, 0);
    check("rst_first", o_first, 0);
    check("rst_num", o_num, 0);
    check("rst_busy", o_busy, 0);
    rst_n = 1;

    // AC with NVB=0x20: whole UID requested
    soc(0); byte8(8'h93);
    check("ac20_busy_mid", o_busy, 1);
    byte8(8'h20);
    eoc_check("ac20", 0, 1, 0);
    check("ac20_data", o_data, 40'h08_12345678);
    check("ac20_first", o_first, 0);
    check("ac20_num", o_num, 40);

    // AC with one known bit, matching and not
    soc(0); byte8(8'h93); byte8(8'h21); bits(40'h0, 1);
    eoc_check("ac21_ok", 0, 1, 0);
    check("ac21_first", o_first, 1);
    check("ac21_num", o_num, 39);
    soc(0); byte8(8'h93); byte8(8'h21); bits(40'h1, 1);
    eoc_check("ac21_bad", 0, 0, 0);

    // AC with 20 known bits
    soc(0); byte8(8'h93); byte8(8'h44); bits(40'h08_12345678, 20);
    eoc_check("ac44", 0, 1, 0);
    check("ac44_first", o_first, 20);
    check("ac44_num", o_num, 20);

    // Extra bit after a complete AC frame
    soc(0); byte8(8'h93); byte8(8'h20); bits(40'h1, 1);
    eoc_check("ac_extra", 0, 0, 0);

    // SELECT single UID, good and bad CRC
    soc(0); byte8(8'h93); byte8(8'h70); bits(40'h08_12345678, 40); bits(40'hABCD, 16);
    eoc_check("sel_s", 1, 0, 1);
    check("sel_s_cmp", o_cmp, 1);
    soc(0); byte8(8'h93); byte8(8'h70); bits(40'h08_12345678, 40); bits(40'hABCD, 16);
    eoc_check("sel_s_badcrc", 0, 0, 0);

    // Double UID, CL1 then CL2
    dsel = 1;
    soc(0); byte8(8'h93); byte8(8'h70); bits(40'hCC_55667788, 40); bits(40'h1234, 16);
    eoc_check("sel_d1", 1, 0, 1);
    check("sel_d1_cmp", o_cmp, 0);
    check("sel_d1_data", o_data, 40'hCC_55667788);
    soc(1); byte8(8'h95); byte8(8'h70); bits(40'h44_11223344, 40); bits(40'h1234, 16);
    eoc_check("sel_d2", 1, 0, 1);
    check("sel_d2_cmp", o_cmp, 1);
    check("sel_d2_data", o_data, 40'h44_11223344);
    soc(1); byte8(8'h93); byte8(8'h20);
    eoc_check("d2_wrongsel", 0, 0, 0);
    soc(0); byte8(8'h95); byte8(8'h20);
    eoc_check("d1_sel2", 0, 0, 0);

    // Invalid NVB values and illegal level
    dsel = 0;
    soc(0); byte8(8'h93); byte8(8'h71);
    check("nvb71_busy", o_busy, 1);
    eoc_check("nvb71", 0, 0, 0);
    soc(0); byte8(8'h93); byte8(8'h80);
    eoc_check("nvb80", 0, 0, 0);
    soc(1); byte8(8'h95); byte8(8'h20);
    eoc_check("s_cl2", 0, 0, 0);

    // Decode error mid-UID, then a clean AC frame
    soc(0); byte8(8'h93); byte8(8'h70); bits(40'h08_12345678, 20);
    @(negedge clk); clr(); rx_error = 1;
    @(negedge clk); clr();
    check("err_busy", o_busy, 0);
    eoc_check("err_eoc", 1, 0, 0);
    soc(0); byte8(8'h93); byte8(8'h20);
    eoc_check("after_err", 0, 1, 0);

    // Restart mid-UID with wrong bits already seen
    soc(0); byte8(8'h93); byte8(8'h70); bits(~40'h08_12345678, 10);
    soc(0); byte8(8'h93); byte8(8'h70); bits(40'h08_12345678, 40); bits(40'h5555, 16);
    eoc_check("restart", 1, 0, 1);

    // Reset mid-frame
    soc(0); byte8(8'h93); byte8(8'h70); bits(40'h08_12345678, 12);
    @(negedge clk); clr(); rst_n = 0;
    @(negedge clk);
    check("mrst_busy", o_busy, 0);
    check("mrst_data", o_data, 0);
    check("mrst_cmp", o_cmp, 0);
    check("mrst_num", o_num, 0);
    rst_n = 1;
    eoc_check("mrst_eoc", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ac_select_matcher.md
Name: ac_select_matcher

Overview:
- Sits directly downstream of the PCD frame decoder. It consumes the decoded LSB-first bit stream of a received frame and parses ANTICOLLISION/SELECT commands (cascade level byte, NVB, UID data, CRC).
- It compares the received UID-data bits on the fly against this tag's UID for the current cascade level.
- At end of frame it pulses a match result to the initialisation FSM. For anticollision matches it also supplies the remaining UID bits to send.

Parameters:
- UID_SIZE, UIDSize_DOUBLE, tag UID size (UIDSize enum from the shared package).
- UID_BITS, get_uid_bits(UID_SIZE), derived width of the uid port; not overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uid  in  UID_BITS  tag UID, byte 0 at [7:0]; static after reset
- cascade_level  in  2  active level, 0=CL1, 1=CL2, 2=CL3; sampled at rx_soc
- rx_soc  in  1  start of frame pulse
- rx_valid  in  1  rx_bit valid this cycle
- rx_bit  in  1  data bit, LSB first, parity already stripped
- rx_eoc  in  1  end of frame pulse
- rx_error  in  1  frame decode error pulse
- rx_crc_ok  in  1  CRC_A check result, valid in the rx_eoc cycle
- ac_match  out  1  one-cycle pulse: valid AC frame matched our UID prefix
- sel_match  out  1  one-cycle pulse: valid SELECT for our UID with good CRC
- sel_uid_complete  out  1  qualifies sel_match: this level completes the UID (SAK choice)
- reply_data  out  40  expected UID data (4 UID bytes + BCC), bit 0 transmitted first
- reply_first_bit  out  6  index into reply_data of the first bit to transmit
- reply_num_bits  out  6  number of bits to transmit
- busy  out  1  frame being parsed

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Expected data for the level is registered at rx_soc.
  - Single UID: uid[31:0].
  - Double UID: CL1 = CASCADE_TAG, uid[23:0]; CL2 = uid[55:24].
  - Triple UID: CL1 = CT, uid[23:0]; CL2 = CT, uid[47:24]; CL3 = uid[79:48].
  - BCC = XOR of the 4 bytes. reply_data = {BCC, bytes}.
  - Illegal level for the UID size: the frame is ignored.
- sel_uid_complete = 1 when cascade_level is the last level for UID_SIZE.
- FSM states: IDLE, CMD, NVB, UID, CRC, WAIT_EOC, IGNORE.
  - rx_soc from any state: go to CMD, clear the 6-bit bit counter and the mismatch flag, set busy. rx_soc has priority over everything else.
  - CMD: 8 bits. If the byte is not SEL1/SEL2/SEL3 for cascade_level, go to IGNORE.
  - NVB: 8 bits, read as NVB struct.
    - rsvd bits nonzero: IGNORE.
    - 0x70 means SELECT, n=40.
    - Otherwise AC, requiring bytes 2..6 (bits 0..7), or bytes=7 with bits=0 treated as SELECT-without-CRC, which is IGNORE. Any other value: IGNORE.
    - For AC, n = (bytes-2)*8 + bits, range 0..39.
    - If n=0, go to WAIT_EOC; else go to UID.
  - UID: bit k compared to expected[k]. Any difference sets mismatch. After n bits: SELECT goes to CRC, AC goes to WAIT_EOC.
  - CRC: count 16 bits, then go to WAIT_EOC.
  - WAIT_EOC: any further rx_valid goes to IGNORE.
  - rx_eoc in any state other than WAIT_EOC: no pulse, go to IDLE.
  - IGNORE: drop everything until the next rx_soc; rx_eoc goes to IDLE.
- rx_eoc in WAIT_EOC with mismatch=0:
  - AC: ac_match=1, reply_first_bit=n, reply_num_bits=40-n.
  - SELECT: sel_match=rx_crc_ok.
  - Pulses are asserted the cycle after the rx_eoc cycle (1-cycle latency). Then go to IDLE and clear busy.
- rx_valid and rx_eoc in the same cycle: the bit is processed first, then the eoc using the updated state.
- rx_error in any state: go to IDLE immediately, no pulse, busy=0.
- reply_* hold their value until the next rx_soc.
- Reset mid-frame: immediate IDLE; no pulse after release until a new rx_soc.

Decomposition:
- Shared package additions:
  - AcSelState enum.
  - function get_num_levels(UIDSize).
  - function sel_for_level(level) returning SEL1/SEL2/SEL3.
- Existing NVB struct, CASCADE_TAG and SEL constants reused.
- One sub-module: uid_level_select. Combinational; maps (uid, UID_SIZE, cascade_level) to the 40-bit expected data plus a level_valid flag. Separately unit-testable.

Test Plan:
- Single UID 0x12345678, CL1: 0x93, 0x20, eoc -> ac_match=1, reply_data BCC=0x08, first_bit=0, num_bits=40.
- Same UID: 0x93, 0x21, bit0=0, eoc -> ac_match, first_bit=1, num_bits=39. bit0=1 -> no pulse.
- Single UID: 0x93, 0x70, 78 56 34 12 08, CRC, eoc with rx_crc_ok=1 -> sel_match=1, sel_uid_complete=1. With rx_crc_ok=0 -> no pulse.
- Double UID 0x11223344556677, CL1: SELECT with 88 77 66 55 BCC=0x88^0x77^0x66^0x55 -> sel_match, sel_uid_complete=0. CL2 with 0x95 on bytes 44 33 22 11 -> sel_uid_complete=1. 0x93 at CL2 -> no pulse.
- Invalid NVB 0x71 or 0x80, and 0x95 at CL1 -> no pulse, busy clears at eoc.
- rx_error after 20 UID bits -> busy=0, no pulse. Next valid AC frame matches. rx_soc mid-UID restarts cleanly. rst_n low mid-frame -> all outputs 0.
